// File: rtl/freq_meas_if.sv
// Scheduler-facing bundle: control inputs, datapath mux/gate/count handshake,
// and the result handshake towards the consumer.
interface freq_meas_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              start_en;
    logic [NUM_CH-1:0] ch_mask;
    logic [CH_W-1:0]   ch_sel;
    logic              gate;
    logic              cnt_vld;
    logic [47:0]       cnt_test;
    logic [47:0]       cnt_stand;
    logic [31:0]       freq;
    logic [CH_W-1:0]   freq_ch;
    logic              freq_err;
    logic              freq_vld;
    logic              freq_rdy;
    logic              busy;

    modport master (
        input  start_en, ch_mask, cnt_vld, cnt_test, cnt_stand, freq_rdy,
        output ch_sel, gate, freq, freq_ch, freq_err, freq_vld, busy
    );

    modport slave (
        output start_en, ch_mask, cnt_vld, cnt_test, cnt_stand, freq_rdy,
        input  ch_sel, gate, freq, freq_ch, freq_err, freq_vld, busy
    );
endinterface

// File: rtl/freq_meas_sched.sv
// Round-robin frequency measurement scheduler: selects a channel, settles, gates
// the counters, then turns the captured counts into Hz with a serial divider.
module freq_meas_sched #(
    parameter int NUM_CH         = 4,
    parameter int GATE_CYCLES    = 750000,
    parameter int SETTLE_CYCLES  = 125000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CLK_STAND_FREQ = 100000000
) (
    input logic         sys_clk,
    input logic         sys_rst,
    freq_meas_if.master bus
);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NUM_W     = 75;
    localparam int DEN_W     = 48;
    localparam int DIV_STEPS = NUM_W;
    localparam int T_A       = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int T_B       = (T_A > TIMEOUT_CYCLES) ? T_A : TIMEOUT_CYCLES;
    localparam int TMR_MAX   = (T_B > DIV_STEPS + 1) ? T_B : DIV_STEPS + 1;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_END  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_END    = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_END = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] DIV_END     = TMR_W'(DIV_STEPS);
    localparam logic [26:0]      STAND_HZ    = 27'(CLK_STAND_FREQ);

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE, GATE, WAIT_CNT, DIV, OUT
    } state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic        err;
    } result_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  tmr;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   pick, pick_nxt;
    logic              pick_found;
    logic [NUM_CH-1:0] m_sh;
    int                j;
    logic              pick_ld, cap_ld, div_step, res_ld;
    result_t           res_n;

    logic [NUM_W-1:0]  dq;
    logic [DEN_W-1:0]  rem, den;
    logic [DEN_W:0]    rem_s, rem_d;
    logic              q_bit;
    logic [NUM_W-1:0]  prod;
    logic [31:0]       quot_sat;

    assign bus.busy = (state != IDLE);

    // Search order starts at rr_ptr, the channel after the last one measured.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        m_sh       = '0;
        j          = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            m_sh = bus.ch_mask >> j;
            if (!pick_found && m_sh[0]) begin
                pick       = CH_W'(j);
                pick_found = 1'b1;
            end
        end
        pick_nxt = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
    end

    // Restoring division: the quotient shifts into dq as the numerator shifts out.
    always_comb begin
        prod     = NUM_W'(STAND_HZ) * NUM_W'(bus.cnt_test);
        rem_s    = {rem, dq[NUM_W-1]};
        rem_d    = rem_s - {1'b0, den};
        q_bit    = ~rem_d[DEN_W];
        quot_sat = (|dq[NUM_W-1:32]) ? 32'hFFFF_FFFF : dq[31:0];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        pick_ld  = 1'b0;
        cap_ld   = 1'b0;
        div_step = 1'b0;
        res_ld   = 1'b0;
        res_n    = '0;
        case (state)
            IDLE: begin
                if (bus.start_en && (|bus.ch_mask)) state_n = SELECT;
            end
            SELECT: begin
                if (pick_found) begin
                    pick_ld = 1'b1;
                    state_n = SETTLE;
                end else begin
                    state_n = IDLE;
                end
            end
            SETTLE: begin
                if (tmr == SETTLE_END) state_n = GATE;
            end
            GATE: begin
                if (tmr == GATE_END) state_n = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (bus.cnt_vld) begin
                    if (bus.cnt_stand == '0) begin
                        res_ld    = 1'b1;
                        res_n.err = 1'b1;
                        state_n   = OUT;
                    end else begin
                        cap_ld  = 1'b1;
                        state_n = DIV;
                    end
                end else if (tmr == TIMEOUT_END) begin
                    res_ld    = 1'b1;
                    res_n.err = 1'b1;
                    state_n   = OUT;
                end
            end
            DIV: begin
                // 75 quotient steps, then one cycle to saturate and publish.
                if (tmr < DIV_END) begin
                    div_step = 1'b1;
                end else begin
                    res_ld     = 1'b1;
                    res_n.freq = quot_sat;
                    state_n    = OUT;
                end
            end
            OUT: begin
                if (bus.freq_rdy) state_n = bus.start_en ? SELECT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One shared timer, cleared on every state change.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || (state_n != state)) tmr <= '0;
        else                              tmr <= tmr + TMR_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr_ptr       <= '0;
            bus.ch_sel   <= '0;
            bus.gate     <= 1'b0;
            bus.freq     <= '0;
            bus.freq_ch  <= '0;
            bus.freq_err <= 1'b0;
            bus.freq_vld <= 1'b0;
        end else begin
            bus.gate     <= (state_n == GATE);
            bus.freq_vld <= (state_n == OUT);
            if (pick_ld) begin
                bus.ch_sel <= pick;
                rr_ptr     <= pick_nxt;
            end
            if (res_ld) begin
                bus.freq     <= res_n.freq;
                bus.freq_err <= res_n.err;
                bus.freq_ch  <= bus.ch_sel;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (cap_ld) begin
            dq  <= prod;
            rem <= '0;
            den <= bus.cnt_stand;
        end else if (div_step) begin
            dq  <= {dq[NUM_W-2:0], q_bit};
            rem <= q_bit ? rem_d[DEN_W-1:0] : rem_s[DEN_W-1:0];
        end
    end
endmodule

// File: doc/freq_meas_sched.md
FREQ_MEAS_SCHED -- requirements
Module: freq_meas_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of test-clock channels; CH_W = max(1, clog2(NUM_CH)).
REQ-002 SHALL have parameter GATE_CYCLES, default 750000, gate-high length in sys_clk cycles.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 125000, gate-low guard after each channel switch.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum wait for counts after the gate falls.
REQ-005 SHALL have parameter CLK_STAND_FREQ, default 100000000, reference clock frequency in Hz (27 bits).
REQ-006 SHALL have port sys_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start_en, input, 1: enables continuous round-robin measurement.
REQ-009 SHALL have port ch_mask, input, NUM_CH: per-channel enable.
REQ-010 SHALL have port ch_sel, output, CH_W: test-clock mux select to the datapath.
REQ-011 SHALL have port gate, output, 1: software gate to the counter datapath.
REQ-012 SHALL have port cnt_vld, input, 1: one-cycle pulse, sys_clk-synchronous, meaning the count inputs are valid.
REQ-013 SHALL have port cnt_test, input, 48: test-clock cycles counted in the gate.
REQ-014 SHALL have port cnt_stand, input, 48: reference-clock cycles counted in the gate.
REQ-015 SHALL have port freq, output, 32: measured frequency in Hz.
REQ-016 SHALL have port freq_ch, output, CH_W: channel that freq belongs to.
REQ-017 SHALL have port freq_err, output, 1: result invalid (timeout or divide-by-zero); qualified by freq_vld.
REQ-018 SHALL have port freq_vld, output, 1: result valid; held until accepted.
REQ-019 SHALL have port freq_rdy, input, 1: consumer accepts the result.
REQ-020 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-021 FSM states SHALL be IDLE, SELECT, SETTLE, GATE, WAIT_CNT, DIV, OUT.
REQ-022 IDLE SHALL go to SELECT when start_en=1 and ch_mask!=0; otherwise it stays in IDLE.
REQ-023 SELECT (1 cycle) SHALL:
- sample ch_mask;
- pick the next set bit strictly after the last measured channel, wrapping to bit 0 (first pick after reset searches from channel 0);
- drive ch_sel;
- go to SETTLE; if the sampled mask=0, go to IDLE.
REQ-024 ch_sel SHALL change only on leaving SELECT and SHALL stay stable through SETTLE to OUT.
REQ-025 SETTLE SHALL hold gate=0 for exactly SETTLE_CYCLES cycles, then enter GATE.
REQ-026 GATE SHALL drive a registered gate=1 for exactly GATE_CYCLES consecutive cycles, then enter WAIT_CNT with gate=0.
REQ-027 WAIT_CNT capture:
- SHALL capture cnt_test/cnt_stand on the first cnt_vld=1 cycle and then enter DIV;
- cnt_vld in any other state SHALL be ignored.
REQ-028 WAIT_CNT timeout: if TIMEOUT_CYCLES cycles elapse without cnt_vld, SHALL go to OUT with freq=0 and freq_err=1.
REQ-029 DIV SHALL compute floor(CLK_STAND_FREQ*cnt_test/cnt_stand):
- 75-bit unsigned numerator;
- sequential restoring division, one quotient bit per cycle;
- total latency from the capture cycle to freq_vld rising = 77 cycles, fixed.
REQ-030 Saturation: a quotient above 2^32-1 SHALL give freq=32'hFFFFFFFF with freq_err=0.
REQ-031 Divide-by-zero: cnt_stand=0 SHALL skip division and go to OUT next cycle with freq=0 and freq_err=1.
REQ-032 OUT handshake:
- freq_vld=1, with freq, freq_ch and freq_err stable, until the cycle with freq_rdy=1;
- freq_vld SHALL deassert in the next cycle;
- then go to SELECT if start_en=1, else IDLE.
REQ-033 start_en falling mid-measurement SHALL NOT abort; the current result completes through OUT.
REQ-034 ch_mask changes outside SELECT SHALL have no effect on the current measurement.
REQ-035 freq_vld SHALL never be high in two consecutive results without an intervening freq_rdy handshake.

Reset
REQ-036 When sys_rst=1 at a clock edge, the block SHALL abort any state and next cycle have:
- state IDLE;
- gate=0, ch_sel=0, freq=0, freq_ch=0, freq_err=0, freq_vld=0, busy=0;
- round-robin pointer cleared so the next pick starts from channel 0.

Verification (NUM_CH=4, GATE_CYCLES=100, SETTLE_CYCLES=10, TIMEOUT_CYCLES=50)
REQ-037 Round-robin, normal result:
- stimulus: ch_mask=4'b0101, start_en=1; cnt_vld with cnt_test=1000, cnt_stand=2000; freq_rdy=1;
- response: freq=50000000, freq_err=0, freq_vld 77 cycles after cnt_vld; channel order 0,2,0; gate high exactly 100 cycles.
REQ-038 Divide-by-zero: cnt_stand=0 -> freq=0, freq_err=1, freq_vld one cycle after capture.
REQ-039 Timeout: no cnt_vld after the gate falls -> 50 cycles later freq_vld=1, freq=0, freq_err=1.
REQ-040 Saturation: cnt_test=2^40, cnt_stand=1 -> freq=32'hFFFFFFFF, freq_err=0.
REQ-041 Back-pressure and ignored inputs:
- freq_rdy held low 20 cycles -> freq_vld, freq and freq_ch stable, no new SELECT, gate stays 0;
- a stray cnt_vld during GATE is ignored.
REQ-042 Reset mid-GATE: sys_rst=1 -> next cycle gate=0, busy=0, ch_sel=0; after release the first channel measured is the lowest set bit of ch_mask.
